// File: rtl/mcpi_engine_if.sv
// Host-side bundle for mcpi_engine: batch control, seeding and result reporting.
interface mcpi_engine_if #(
    parameter int unsigned CW = 16
) ();
    logic          start;
    logic          seed_load;
    logic [15:0]   seed;
    logic [CW-1:0] n_samples;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt_total;
    logic [CW-1:0] cnt_in;
    logic          smp_valid;
    logic          smp_in;

    modport master (
        output start, seed_load, seed, n_samples,
        input  busy, done, cnt_total, cnt_in, smp_valid, smp_in
    );

    modport slave (
        input  start, seed_load, seed, n_samples,
        output busy, done, cnt_total, cnt_in, smp_valid, smp_in
    );
endinterface

// File: rtl/mcpi_engine.sv
// Monte Carlo pi estimator: LFSR-drawn (x, y) pairs, sequential shift-add squaring,
// and inside-unit-circle counting over a programmable batch.
module mcpi_engine #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 16
) (
    input logic            clk,
    input logic            rst,
    mcpi_engine_if.slave   bus
);
    localparam int unsigned SW = 2 * W + 1;
    localparam int unsigned BW = $clog2(W + 1);
    localparam logic [15:0] Taps = 16'hB400;

    typedef enum logic [2:0] {
        StIdle,
        StLoadX,
        StSqX,
        StLoadY,
        StSqY,
        StCmp,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   cnt_total_q, cnt_total_d;
    logic [CW-1:0]   cnt_in_q, cnt_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            smp_valid_q, smp_valid_d;
    logic            smp_in_q, smp_in_d;

    logic [15:0]     lfsr_adv;
    logic [2*W-1:0]  acc_step;
    logic            sq_last;
    logic            more;

    // Next-state and registered-output computation for the whole engine.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        opnd_d      = opnd_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        bit_d       = bit_q;
        sum_d       = sum_q;
        n_d         = n_q;
        cnt_total_d = cnt_total_q;
        cnt_in_d    = cnt_in_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        smp_valid_d = 1'b0;
        smp_in_d    = smp_in_q;

        lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : 16'h0000);
        // The multiplicand copy is pre-shifted each cycle, so it always equals copy << bit index.
        acc_step = acc_q + (opnd_q[0] ? mcand_q : '0);
        sq_last  = (bit_q == BW'(W - 1));
        more     = (({1'b0, cnt_total_q} + {{CW{1'b0}}, 1'b1}) < {1'b0, n_q});

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    n_d         = bus.n_samples;
                    cnt_total_d = '0;
                    cnt_in_d    = '0;
                    busy_d      = 1'b1;
                    if (bus.n_samples == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StLoadX;
                    end
                end else if (bus.seed_load) begin
                    lfsr_d = (bus.seed == 16'h0000) ? 16'h0001 : bus.seed;
                end
            end
            StLoadX, StLoadY: begin
                lfsr_d  = lfsr_adv;
                opnd_d  = lfsr_adv[W-1:0];
                mcand_d = {{W{1'b0}}, lfsr_adv[W-1:0]};
                acc_d   = '0;
                bit_d   = '0;
                if (state_q == StLoadX) begin
                    sum_d   = '0;
                    state_d = StSqX;
                end else begin
                    state_d = StSqY;
                end
            end
            StSqX, StSqY: begin
                acc_d   = acc_step;
                opnd_d  = opnd_q >> 1;
                mcand_d = mcand_q << 1;
                bit_d   = bit_q + BW'(1);
                if (sq_last) begin
                    sum_d = sum_q + {1'b0, acc_step};
                    if (state_q == StSqX) begin
                        state_d = StLoadY;
                    end else begin
                        state_d     = StCmp;
                        smp_valid_d = 1'b1;
                        // Inside when x^2 + y^2 < 2^(2W), i.e. the top sum bit is clear.
                        smp_in_d    = ~sum_d[SW-1];
                    end
                end
            end
            StCmp: begin
                cnt_total_d = cnt_total_q + CW'(1);
                cnt_in_d    = cnt_in_q + {{(CW - 1){1'b0}}, smp_in_q};
                if (more) begin
                    state_d = StLoadX;
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lfsr_q      <= 16'h0001;
            opnd_q      <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            bit_q       <= '0;
            sum_q       <= '0;
            n_q         <= '0;
            cnt_total_q <= '0;
            cnt_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            smp_valid_q <= 1'b0;
            smp_in_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            opnd_q      <= opnd_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            bit_q       <= bit_d;
            sum_q       <= sum_d;
            n_q         <= n_d;
            cnt_total_q <= cnt_total_d;
            cnt_in_q    <= cnt_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            smp_valid_q <= smp_valid_d;
            smp_in_q    <= smp_in_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cnt_total = cnt_total_q;
    assign bus.cnt_in    = cnt_in_q;
    assign bus.smp_valid = smp_valid_q;
    assign bus.smp_in    = smp_in_q;
endmodule

// File: tb/tb_mcpi_engine.sv
// Self-checking bench for mcpi_engine: directed batches plus long seeded runs
// compared sample-by-sample against an arithmetic model of the LFSR and squares.
module tb_mcpi_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    mcpi_engine_if #(.CW(16)) bus8 ();
    mcpi_engine_if #(.CW(16)) bus12 ();

    mcpi_engine #(.W(8), .CW(16)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    mcpi_engine #(.W(12), .CW(16)) dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12)
    );

    always #5 clk = ~clk;

    // Model state: LFSR value and count of inside samples in the current batch.
    logic [15:0] m8  = 16'h0001;
    logic [15:0] m12 = 16'h0001;
    int          hits8  = 0;
    int          hits12 = 0;
    longint      last_sum8 = 0;
    longint      mx8, my8, mx12, my12;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] seed_val(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    // Per-sample reference: next two LFSR draws give x and y; inside iff x^2+y^2 < 1.
    always @(negedge clk) begin
        if (!rst && bus8.smp_valid) begin
            m8  = lfsr_next(m8);
            mx8 = longint'(m8) % 256;
            m8  = lfsr_next(m8);
            my8 = longint'(m8) % 256;
            check_eq("sum_w8", longint'(dut8.sum_q), mx8 * mx8 + my8 * my8);
            check_eq("smp_in_w8", longint'(bus8.smp_in),
                     longint'((mx8 * mx8 + my8 * my8) < 65536));
            if ((mx8 * mx8 + my8 * my8) < 65536) hits8++;
            last_sum8 = longint'(dut8.sum_q);
        end
        if (!rst && bus12.smp_valid) begin
            m12  = lfsr_next(m12);
            mx12 = longint'(m12) % 4096;
            m12  = lfsr_next(m12);
            my12 = longint'(m12) % 4096;
            check_eq("smp_in_w12", longint'(bus12.smp_in),
                     longint'((mx12 * mx12 + my12 * my12) < (64'd1 << 24)));
            if ((mx12 * mx12 + my12 * my12) < (64'd1 << 24)) hits12++;
        end
    end

    task automatic load_seed8(input logic [15:0] s);
        @(negedge clk);
        bus8.seed      = s;
        bus8.seed_load = 1'b1;
        @(negedge clk);
        bus8.seed_load = 1'b0;
        m8 = seed_val(s);
        check_eq("seed_lfsr", longint'(dut8.lfsr_q), longint'(m8));
    endtask

    // Runs one batch on the W=8 engine; cycle 1 is the first cycle after the start edge.
    task automatic run8(input int n, input bit poke_mid, input bit seed_with_start,
                        output int done_cyc, output int tot, output int inn);
        int c;
        done_cyc = -1;
        tot      = -1;
        inn      = -1;
        hits8    = 0;
        @(negedge clk);
        bus8.n_samples = 16'(n);
        bus8.start     = 1'b1;
        if (seed_with_start) begin
            bus8.seed      = 16'h4321;
            bus8.seed_load = 1'b1;
        end
        @(negedge clk);
        bus8.start     = 1'b0;
        bus8.seed_load = 1'b0;
        c = 1;
        check_eq("busy_c1", longint'(bus8.busy), 1);
        while (c < 60000) begin
            if (poke_mid && c == 30) begin
                bus8.start     = 1'b1;
                bus8.seed      = 16'h1234;
                bus8.seed_load = 1'b1;
            end else begin
                bus8.start     = 1'b0;
                bus8.seed_load = 1'b0;
            end
            if (bus8.done) begin
                done_cyc = c;
                tot      = int'(bus8.cnt_total);
                inn      = int'(bus8.cnt_in);
                break;
            end
            @(negedge clk);
            c++;
        end
        if (done_cyc < 0) check_eq("done_timeout", 0, 1);
        @(negedge clk);
        check_eq("busy_after", longint'(bus8.busy), 0);
        check_eq("done_pulse", longint'(bus8.done), 0);
        check_eq("cnt_hold", longint'(bus8.cnt_total), longint'(tot));
    endtask

    initial begin
        int dc, tot, inn, c, seen;
        bus8.start      = 1'b0;
        bus8.seed_load  = 1'b0;
        bus8.seed       = 16'h0000;
        bus8.n_samples  = '0;
        bus12.start     = 1'b0;
        bus12.seed_load = 1'b0;
        bus12.seed      = 16'h0000;
        bus12.n_samples = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", longint'(bus8.busy), 0);
        check_eq("rst_done", longint'(bus8.done), 0);
        check_eq("rst_total", longint'(bus8.cnt_total), 0);
        check_eq("rst_in", longint'(bus8.cnt_in), 0);
        check_eq("rst_valid", longint'(bus8.smp_valid), 0);
        check_eq("rst_smp_in", longint'(bus8.smp_in), 0);
        check_eq("rst_lfsr", longint'(dut8.lfsr_q), 1);

        // Seed 1: both coordinates are zero, so the sample is inside.
        load_seed8(16'h0001);
        run8(1, 1'b0, 1'b0, dc, tot, inn);
        check_eq("s1_done_cyc", dc, 20);
        check_eq("s1_total", tot, 1);
        check_eq("s1_in", inn, 1);
        check_eq("s1_lfsr", longint'(dut8.lfsr_q), 16'h5A00);

        // Seed FFFF: x = y = 0xFF, well outside.
        load_seed8(16'hFFFF);
        run8(1, 1'b0, 1'b0, dc, tot, inn);
        check_eq("sF_done_cyc", dc, 20);
        check_eq("sF_total", tot, 1);
        check_eq("sF_in", inn, 0);
        check_eq("sF_sum", last_sum8, 130050);
        check_eq("sF_lfsr", longint'(dut8.lfsr_q), 16'hD1FF);

        // Seed 0 is replaced by 1.
        load_seed8(16'h0000);
        check_eq("s0_lfsr", longint'(dut8.lfsr_q), 1);
        run8(1, 1'b0, 1'b0, dc, tot, inn);
        check_eq("s0_in", inn, 1);
        check_eq("s0_lfsr_after", longint'(dut8.lfsr_q), 16'h5A00);

        // Empty batch.
        run8(0, 1'b0, 1'b0, dc, tot, inn);
        check_eq("n0_done_cyc", dc, 1);
        check_eq("n0_total", tot, 0);
        check_eq("n0_in", inn, 0);

        // start/seed_load pulsed mid-batch must be ignored.
        run8(5, 1'b1, 1'b0, dc, tot, inn);
        check_eq("n5_done_cyc", dc, 96);
        check_eq("n5_total", tot, 5);
        check_eq("n5_in", inn, hits8);
        check_eq("n5_lfsr", longint'(dut8.lfsr_q), longint'(m8));

        // start and seed_load together: start wins, seed dropped.
        run8(2, 1'b0, 1'b1, dc, tot, inn);
        check_eq("both_done_cyc", dc, 39);
        check_eq("both_in", inn, hits8);
        check_eq("both_lfsr", longint'(dut8.lfsr_q), longint'(m8));

        // Reset in the middle of a 10-sample batch.
        @(negedge clk);
        bus8.n_samples = 16'd10;
        bus8.start     = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        c = 1;
        while (c < 40) begin
            @(negedge clk);
            c++;
        end
        check_eq("mid_total_c40", longint'(bus8.cnt_total), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m8  = 16'h0001;
        m12 = 16'h0001;
        check_eq("mid_busy", longint'(bus8.busy), 0);
        check_eq("mid_total", longint'(bus8.cnt_total), 0);
        check_eq("mid_in", longint'(bus8.cnt_in), 0);
        check_eq("mid_done", longint'(bus8.done), 0);
        check_eq("mid_lfsr", longint'(dut8.lfsr_q), 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) seen++;
        end
        check_eq("mid_quiet", seen, 0);

        // Long W=8 run; consecutive draws from one LFSR are correlated, so the
        // hit-rate window is deliberately loose while the model match is exact.
        load_seed8(16'hACE1);
        run8(1000, 1'b0, 1'b0, dc, tot, inn);
        check_eq("w8_done_cyc", dc, 19001);
        check_eq("w8_total", tot, 1000);
        check_eq("w8_in_model", inn, hits8);
        check_eq("w8_in_range", longint'(inn >= 700 && inn <= 850), 1);

        // Long W=12 run on the second engine.
        @(negedge clk);
        bus12.seed      = 16'hACE1;
        bus12.seed_load = 1'b1;
        @(negedge clk);
        bus12.seed_load = 1'b0;
        m12    = 16'hACE1;
        hits12 = 0;
        bus12.n_samples = 16'd1000;
        bus12.start     = 1'b1;
        @(negedge clk);
        bus12.start = 1'b0;
        c  = 1;
        dc = -1;
        while (c < 40000) begin
            if (bus12.done) begin
                dc  = c;
                tot = int'(bus12.cnt_total);
                inn = int'(bus12.cnt_in);
                break;
            end
            @(negedge clk);
            c++;
        end
        check_eq("w12_done_cyc", dc, 27001);
        check_eq("w12_total", tot, 1000);
        check_eq("w12_in_model", inn, hits12);
        check_eq("w12_in_range", longint'(inn >= 700 && inn <= 850), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
